psram_dma_xfer: RTL and testbench

- Transfer engine directly downstream of the PSRAM DMA task sequencer.
- Consumes the latched task descriptor cfg0..cfg3 on a start pulse.
- Moves 32-bit words between local SRAM and the PSRAM controller in page-safe bursts, then returns a one-cycle done.
- Descriptor fields: cfg0 = SRAM byte address, cfg1 = PSRAM byte address, cfg2 = length and direction. cfg3 belongs to the sequencer (chaining) and is not used here.

---
 rtl/psram_dma_pkg.sv | 38 +++
 rtl/psram_xfer_buf.sv | 52 +++++
 rtl/psram_dma_xfer.sv | 196 +++++++++++++++++++
 tb/tb_psram_dma_xfer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psram_dma_pkg.sv
// Shared definitions for the PSRAM DMA sequencer and transfer engine:
// FSM encoding, descriptor field positions and burst sizing.
package psram_dma_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CALC,
    ST_SRD,
    ST_PCMD,
    ST_PWR,
    ST_PRD,
    ST_SWR,
    ST_NEXT,
    ST_DONE
  } state_t;

  // cfg2: transfer length and direction
  localparam int LEN_LSB = 0;
  localparam int LEN_MSB = 15;
  localparam int DIR_BIT = 31;

  // cfg3: chaining fields, owned by the sequencer
  localparam int CHAIN_EN_BIT  = 31;
  localparam int CHAIN_IDX_LSB = 0;
  localparam int CHAIN_IDX_MSB = 3;

  // Words in the next burst: limited by what is left, the burst cap and the page end.
  function automatic int unsigned burst_words(input int unsigned rem,
                                              input int unsigned bmax,
                                              input int unsigned room);
    int unsigned n;
    n = rem;
    if (n > bmax) n = bmax;
    if (n > room) n = room;
    return n;
  endfunction

endpackage

// File: rtl/psram_xfer_buf.sv
// Burst staging FIFO between the SRAM and PSRAM sides; holds one full burst.
module psram_xfer_buf #(
  parameter int DEPTH = 16,
  parameter int W     = 32,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic          do_push, do_pop;

  assign do_pop  = pop && (cnt != '0);
  assign do_push = push && ((cnt != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  // NOTE: storage has no reset; only the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign empty = (cnt == '0);
  assign count = cnt;

endmodule

// File: rtl/psram_dma_xfer.sv
// Moves words between local SRAM and the PSRAM controller in page-safe
// bursts for one descriptor, then pulses done.
module psram_dma_xfer
  import psram_dma_pkg::*;
#(
  parameter int BURST_MAX  = 16,
  parameter int PAGE_WORDS = 256,
  parameter int PA_W       = 24
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            dma_en,
  input  logic            start,
  input  logic [31:0]     cfg0,
  input  logic [31:0]     cfg1,
  input  logic [31:0]     cfg2,
  input  logic [31:0]     cfg3,
  output logic            done,
  output logic            busy,
  output logic            sram_req,
  output logic            sram_we,
  output logic [16:0]     sram_addr,
  output logic [31:0]     sram_wdata,
  input  logic            sram_ack,
  input  logic [31:0]     sram_rdata,
  output logic            psram_cmd_valid,
  input  logic            psram_cmd_ready,
  output logic            psram_cmd_we,
  output logic [PA_W-1:0] psram_cmd_addr,
  output logic [8:0]      psram_cmd_len,
  output logic            psram_wvalid,
  input  logic            psram_wready,
  output logic [31:0]     psram_wdata,
  input  logic            psram_rvalid,
  input  logic [31:0]     psram_rdata,
  input  logic            psram_burst_done
);

  localparam int PW_W  = PA_W - 2;
  localparam int PG_W  = $clog2(PAGE_WORDS);
  localparam int CNT_W = $clog2(BURST_MAX) + 1;

  typedef struct packed {
    state_t          state;
    logic [14:0]     sa;
    logic [PW_W-1:0] pa;
    logic [15:0]     rem;
    logic            dir;
    logic [8:0]      n;
    logic [8:0]      cnt;
    logic            bd_seen;
    logic            done;
    logic            sram_req;
    logic            sram_we;
    logic            cmd_valid;
    logic            cmd_we;
    logic [PA_W-1:0] cmd_addr;
    logic [8:0]      cmd_len;
  } ctl_t;

  ctl_t             r;
  logic [8:0]       n_calc;
  logic             rd_take, buf_push, buf_pop, buf_empty;
  logic [31:0]      buf_head, buf_wdata;
  logic [CNT_W-1:0] buf_count;
  logic             unused_cfg;

  assign unused_cfg = ^{cfg3, cfg0[31:17], cfg0[1:0], cfg1[31:PA_W], cfg1[1:0], cfg2[30:16]};

  assign n_calc = 9'(burst_words(32'(r.rem), 32'(BURST_MAX),
                                 32'(PAGE_WORDS) - 32'(r.pa[PG_W-1:0])));

  // Read beats past the burst length are dropped rather than buffered.
  assign rd_take   = (r.state == ST_PRD) && psram_rvalid && (r.cnt < r.n);
  assign buf_push  = ((r.state == ST_SRD) && sram_ack) || rd_take;
  assign buf_wdata = (r.state == ST_SRD) ? sram_rdata : psram_rdata;
  assign buf_pop   = (psram_wvalid && psram_wready) || ((r.state == ST_SWR) && sram_ack);

  psram_xfer_buf #(.DEPTH(BURST_MAX), .W(32)) u_buf (
    .clk   (clk),
    .rstn  (rstn),
    .flush (!dma_en),
    .push  (buf_push),
    .wdata (buf_wdata),
    .pop   (buf_pop),
    .rdata (buf_head),
    .empty (buf_empty),
    .count (buf_count)
  );

  // NOTE: sequential state uses <= only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r <= '0;
    end else if (!dma_en) begin
      r <= '0;
    end else begin
      r.done <= 1'b0;
      unique case (r.state)
        ST_IDLE: if (start) begin
          r.sa    <= cfg0[16:2];
          r.pa    <= cfg1[PA_W-1:2];
          r.rem   <= cfg2[LEN_MSB:LEN_LSB];
          r.dir   <= cfg2[DIR_BIT];
          r.state <= ST_CALC;
        end
        ST_CALC: begin
          if (r.rem == '0) begin
            r.state <= ST_DONE;
          end else begin
            r.n   <= n_calc;
            r.cnt <= '0;
            if (r.dir) begin
              r.cmd_valid <= 1'b1;
              r.cmd_we    <= 1'b0;
              r.cmd_addr  <= {r.pa, 2'b00};
              r.cmd_len   <= n_calc;
              r.state     <= ST_PCMD;
            end else begin
              r.sram_req <= 1'b1;
              r.sram_we  <= 1'b0;
              r.state    <= ST_SRD;
            end
          end
        end
        ST_SRD: if (sram_ack) begin
          r.sa  <= r.sa + 15'd1;
          r.cnt <= r.cnt + 9'd1;
          if (r.cnt == r.n - 9'd1) begin
            r.sram_req  <= 1'b0;
            r.cmd_valid <= 1'b1;
            r.cmd_we    <= 1'b1;
            r.cmd_addr  <= {r.pa, 2'b00};
            r.cmd_len   <= r.n;
            r.state     <= ST_PCMD;
          end
        end
        ST_PCMD: if (psram_cmd_ready) begin
          r.cmd_valid <= 1'b0;
          r.cmd_we    <= 1'b0;
          r.cmd_addr  <= '0;
          r.cmd_len   <= '0;
          r.bd_seen   <= 1'b0;
          r.cnt       <= '0;
          r.state     <= r.dir ? ST_PRD : ST_PWR;
        end
        ST_PWR: begin
          // burst_done can coincide with the last beat, so it is remembered.
          if (psram_burst_done) r.bd_seen <= 1'b1;
          if (buf_empty && (r.bd_seen || psram_burst_done)) r.state <= ST_NEXT;
        end
        ST_PRD: begin
          if (psram_burst_done) r.bd_seen <= 1'b1;
          if (rd_take) r.cnt <= r.cnt + 9'd1;
          if ((r.cnt == r.n) && (r.bd_seen || psram_burst_done)) begin
            r.sram_req <= 1'b1;
            r.sram_we  <= 1'b1;
            r.state    <= ST_SWR;
          end
        end
        ST_SWR: if (sram_ack) begin
          r.sa <= r.sa + 15'd1;
          if (buf_count == CNT_W'(1)) begin
            r.sram_req <= 1'b0;
            r.sram_we  <= 1'b0;
            r.state    <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          r.pa    <= r.pa + PW_W'(r.n);
          r.rem   <= r.rem - 16'(r.n);
          r.state <= ST_CALC;
        end
        ST_DONE: begin
          r.done  <= 1'b1;
          r.state <= ST_IDLE;
        end
        default: r.state <= ST_IDLE;
      endcase
    end
  end

  assign done            = r.done;
  assign busy            = (r.state != ST_IDLE);
  assign sram_req        = r.sram_req;
  assign sram_we         = r.sram_we;
  assign sram_addr       = {r.sa, 2'b00};
  assign sram_wdata      = r.sram_we ? buf_head : '0;
  assign psram_cmd_valid = r.cmd_valid;
  assign psram_cmd_we    = r.cmd_we;
  assign psram_cmd_addr  = r.cmd_addr;
  assign psram_cmd_len   = r.cmd_len;
  assign psram_wvalid    = (r.state == ST_PWR) && !buf_empty;
  assign psram_wdata     = psram_wvalid ? buf_head : '0;

endmodule

// File: tb/tb_psram_dma_xfer.sv
// Scoreboard bench: SRAM and PSRAM controller models check every beat against
// expectations queued when each descriptor is issued.
module tb_psram_dma_xfer;

  localparam int BURST_MAX  = 16;
  localparam int PAGE_WORDS = 256;
  localparam int PA_W       = 24;
  localparam int unsigned PMASK = 32'h003F_FFFF;
  localparam int unsigned SMASK = 32'h0000_7FFF;

  logic clk, rstn, dma_en, start;
  logic [31:0] cfg0, cfg1, cfg2, cfg3;
  logic done, busy, sram_req, sram_we, sram_ack;
  logic [16:0] sram_addr;
  logic [31:0] sram_wdata, sram_rdata;
  logic psram_cmd_valid, psram_cmd_ready, psram_cmd_we;
  logic [PA_W-1:0] psram_cmd_addr;
  logic [8:0] psram_cmd_len;
  logic psram_wvalid, psram_wready, psram_rvalid, psram_burst_done;
  logic [31:0] psram_wdata, psram_rdata;

  psram_dma_xfer #(.BURST_MAX(BURST_MAX), .PAGE_WORDS(PAGE_WORDS), .PA_W(PA_W)) dut (
    .clk(clk), .rstn(rstn), .dma_en(dma_en), .start(start),
    .cfg0(cfg0), .cfg1(cfg1), .cfg2(cfg2), .cfg3(cfg3),
    .done(done), .busy(busy),
    .sram_req(sram_req), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_ack(sram_ack), .sram_rdata(sram_rdata),
    .psram_cmd_valid(psram_cmd_valid), .psram_cmd_ready(psram_cmd_ready),
    .psram_cmd_we(psram_cmd_we), .psram_cmd_addr(psram_cmd_addr), .psram_cmd_len(psram_cmd_len),
    .psram_wvalid(psram_wvalid), .psram_wready(psram_wready), .psram_wdata(psram_wdata),
    .psram_rvalid(psram_rvalid), .psram_rdata(psram_rdata), .psram_burst_done(psram_burst_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  typedef struct { int unsigned addr; logic [31:0] data; } beat_t;
  typedef struct { int unsigned addr; int unsigned len; bit we; } cmd_t;

  beat_t       exp_pw[$];
  beat_t       exp_sw[$];
  int unsigned exp_srd[$];
  cmd_t        exp_cmd[$];

  logic [31:0] smem [32768];
  logic [31:0] pmem [int unsigned];

  function automatic logic [31:0] pget(input int unsigned a);
    return pmem.exists(a) ? pmem[a] : ((a * 32'h9E37_79B1) ^ 32'h5A5A_0000);
  endfunction

  // Memory and controller responders: sample at negedge, drive for next posedge.
  bit          stall;
  int          ps_phase;
  bit          ps_we, ps_extra;
  int unsigned ps_addr, ps_len, ps_beats;
  beat_t       bt;
  cmd_t        ct;

  initial begin
    sram_ack = 0; sram_rdata = 0; psram_cmd_ready = 0; psram_wready = 0;
    psram_rvalid = 0; psram_rdata = 0; psram_burst_done = 0; ps_phase = 0;
    forever begin
      @(negedge clk);
      sram_ack = 0; sram_rdata = 0; psram_cmd_ready = 0; psram_wready = 0;
      psram_rvalid = 0; psram_rdata = 0; psram_burst_done = 0;
      if (!dma_en || !rstn) begin
        ps_phase = 0;
      end else begin
        if (sram_req && (!stall || $urandom_range(0, 2) != 0)) begin
          sram_ack = 1;
          if (sram_we) begin
            if (exp_sw.size() == 0) check("sram_wr_extra", 32'd1, 32'd0);
            else begin
              bt = exp_sw.pop_front();
              check("sram_wr_addr", 32'(sram_addr), bt.addr);
              check("sram_wr_data", sram_wdata, bt.data);
            end
            smem[sram_addr[16:2]] = sram_wdata;
          end else begin
            if (exp_srd.size() == 0) check("sram_rd_extra", 32'd1, 32'd0);
            else check("sram_rd_addr", 32'(sram_addr), exp_srd.pop_front());
            sram_rdata = smem[sram_addr[16:2]];
          end
        end
        case (ps_phase)
          0: if (psram_cmd_valid && (!stall || $urandom_range(0, 1) == 0)) begin
            psram_cmd_ready = 1;
            if (exp_cmd.size() == 0) check("cmd_extra", 32'd1, 32'd0);
            else begin
              ct = exp_cmd.pop_front();
              check("cmd_addr", 32'(psram_cmd_addr), ct.addr << 2);
              check("cmd_len", 32'(psram_cmd_len), ct.len);
              check("cmd_we", 32'(psram_cmd_we), 32'(ct.we));
            end
            ps_we = psram_cmd_we; ps_addr = 32'(psram_cmd_addr) >> 2;
            ps_len = 32'(psram_cmd_len); ps_beats = 0;
            ps_extra = 1'($urandom_range(0, 1));
            ps_phase = 1;
          end
          1: begin
            if (ps_we) begin
              if (psram_wvalid && (!stall || $urandom_range(0, 2) != 0)) begin
                psram_wready = 1;
                if (exp_pw.size() == 0) check("pwr_extra", 32'd1, 32'd0);
                else begin
                  bt = exp_pw.pop_front();
                  check("pwr_addr", (ps_addr + ps_beats) & PMASK, bt.addr);
                  check("pwr_data", psram_wdata, bt.data);
                end
                pmem[(ps_addr + ps_beats) & PMASK] = psram_wdata;
                ps_beats++;
              end
            end else if (!stall || $urandom_range(0, 2) != 0) begin
              psram_rvalid = 1;
              psram_rdata = pget((ps_addr + ps_beats) & PMASK);
              ps_beats++;
            end
            if (ps_beats == ps_len && (psram_wready || psram_rvalid)) begin
              if ($urandom_range(0, 1) == 1) begin
                psram_burst_done = 1;
                ps_phase = 0;
              end else ps_phase = 2;
            end
          end
          default: begin
            if (!ps_we && ps_extra) begin
              psram_rvalid = 1;
              psram_rdata = 32'hDEAD_BEEF;
              ps_extra = 0;
            end else begin
              psram_burst_done = 1;
              ps_phase = 0;
            end
          end
        endcase
      end
    end
  end

  // Queue every expected SRAM access, PSRAM beat and burst command for one descriptor.
  task automatic plan(input bit dir, input int unsigned sa_b, input int unsigned pa_b,
                      input int unsigned len);
    int unsigned sa, pa, p, r, n, sw, pw;
    sa = (sa_b >> 2) & SMASK;
    pa = (pa_b >> 2) & PMASK;
    for (int unsigned i = 0; i < len; i++) begin
      sw = (sa + i) & SMASK;
      pw = (pa + i) & PMASK;
      if (!dir) begin
        exp_srd.push_back(sw << 2);
        exp_pw.push_back('{pw, smem[sw]});
      end else begin
        exp_sw.push_back('{sw << 2, pget(pw)});
      end
    end
    p = pa; r = len;
    while (r > 0) begin
      n = r;
      if (n > BURST_MAX) n = BURST_MAX;
      if (n > PAGE_WORDS - (p % PAGE_WORDS)) n = PAGE_WORDS - (p % PAGE_WORDS);
      exp_cmd.push_back('{p, n, !dir});
      p = (p + n) & PMASK;
      r -= n;
    end
  endtask

  task automatic kick(input bit dir, input int unsigned sa_b, input int unsigned pa_b,
                      input int unsigned len);
    @(negedge clk);
    start = 1; cfg0 = sa_b; cfg1 = pa_b; cfg2 = {dir, 15'h0, 16'(len)}; cfg3 = $urandom;
    @(negedge clk);
    start = 0;
  endtask

  task automatic flush_q();
    exp_pw.delete(); exp_sw.delete(); exp_srd.delete(); exp_cmd.delete();
  endtask

  // Cycle k counts from the start cycle (k = 0); first_k is the first request.
  task automatic run_xfer(input string nm, input bit dir, input int unsigned sa_b,
                          input int unsigned pa_b, input int unsigned len,
                          output int first_k, output int done_k);
    int dones;
    plan(dir, sa_b, pa_b, len);
    kick(dir, sa_b, pa_b, len);
    first_k = 0; done_k = 0; dones = 0;
    for (int k = 1; k <= 5000 && (done_k == 0 || k <= done_k + 4); k++) begin
      if (k == 1) check({nm, "_busy"}, 32'(busy), 32'd1);
      if (first_k == 0 && (sram_req || psram_cmd_valid)) first_k = k;
      if (done) begin
        dones++;
        if (done_k == 0) done_k = k;
      end
      @(negedge clk);
    end
    if (done_k == 0) check({nm, "_done_timeout"}, 32'd0, 32'd1);
    check({nm, "_done_count"}, 32'(dones), 32'd1);
    check({nm, "_idle_busy"}, 32'(busy), 32'd0);
    check({nm, "_cmd_left"}, 32'(exp_cmd.size()), 32'd0);
    check({nm, "_srd_left"}, 32'(exp_srd.size()), 32'd0);
    check({nm, "_pwr_left"}, 32'(exp_pw.size()), 32'd0);
    check({nm, "_swr_left"}, 32'(exp_sw.size()), 32'd0);
    flush_q();
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int first_k, done_k, dones;

  initial begin
    rstn = 0; dma_en = 0; start = 0; cfg0 = 0; cfg1 = 0; cfg2 = 0; cfg3 = 0; stall = 0;
    for (int i = 0; i < 32768; i++) smem[i] = $urandom;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sram_req", 32'(sram_req), 32'd0);
    check("rst_cmd_valid", 32'(psram_cmd_valid), 32'd0);
    check("rst_wvalid", 32'(psram_wvalid), 32'd0);
    check("rst_sram_addr", 32'(sram_addr), 32'd0);
    check("rst_cmd_addr", 32'(psram_cmd_addr), 32'd0);
    rstn = 1;
    @(negedge clk);
    dma_en = 1;

    // SRAM->PSRAM, single burst
    run_xfer("t1", 1'b0, 32'h100, 32'h0, 4, first_k, done_k);
    check("t1_latency", 32'(first_k), 32'd2);

    // PSRAM->SRAM crossing a page: 2 words then 4
    run_xfer("t2", 1'b1, 32'h2000, 32'h3F8, 6, first_k, done_k);
    check("t2_latency", 32'(first_k), 32'd2);

    // 40 words split 16/16/8, then copied back to a fresh SRAM region
    run_xfer("t3w", 1'b0, 32'h4000, 32'h10000, 40, first_k, done_k);
    run_xfer("t3r", 1'b1, 32'h8000, 32'h10000, 40, first_k, done_k);
    for (int i = 0; i < 40; i++)
      check("t3_roundtrip", smem[32'h2000 + i], smem[32'h1000 + i]);

    // Empty task: no traffic, done three cycles after start
    run_xfer("t4", 1'b0, 32'h40, 32'h80, 0, first_k, done_k);
    check("t4_no_traffic", 32'(first_k), 32'd0);
    check("t4_done_latency", 32'(done_k), 32'd3);

    // Stalled handshakes, address wrap on both sides, random descriptors
    stall = 1;
    run_xfer("t5w", 1'b0, 32'h1FFF8, 32'hFFFFF8, 5, first_k, done_k);
    run_xfer("t5r", 1'b1, 32'h1FFF4, 32'hFFFFF4, 7, first_k, done_k);
    for (int t = 0; t < 8; t++)
      run_xfer("t5rand", 1'($urandom_range(0, 1)), $urandom & 32'h1FFFC,
               $urandom & 32'hFFFFFC, $urandom_range(1, 50), first_k, done_k);
    stall = 0;

    // Abort in the middle of a write burst
    plan(1'b0, 32'h600, 32'h5000, 16);
    kick(1'b0, 32'h600, 32'h5000, 16);
    for (int k = 0; k < 200 && !psram_wvalid; k++) @(negedge clk);
    check("t6_reach_pwr", 32'(psram_wvalid), 32'd1);
    dma_en = 0;
    @(negedge clk);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_wvalid", 32'(psram_wvalid), 32'd0);
    check("t6_sram_req", 32'(sram_req), 32'd0);
    check("t6_cmd_valid", 32'(psram_cmd_valid), 32'd0);
    dones = 0;
    for (int k = 0; k < 6; k++) begin
      if (done) dones++;
      @(negedge clk);
    end
    check("t6_no_done", 32'(dones), 32'd0);
    flush_q();
    dma_en = 1;
    @(negedge clk);
    run_xfer("t6_after", 1'b0, 32'h700, 32'h6000, 20, first_k, done_k);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
